can_bit_stuffer: RTL and testbench

Inserts CAN stuff bits into the serial transmit stream. It sits directly downstream of the CAN transmit frame sequencer and consumes that block's per-bit outputs: `tx_bit`, `stuff_en` and `txing`. It drives the line-level `can_tx` bit and returns `stuff_pending`, which makes the sequencer hold its current bit for one bit-time while a stuff bit goes out. Per CAN 2.0, after five consecutive identical bits in the stuffed region, one bit of opposite polarity is inserted.

---
 rtl/can_bit_stuffer_pkg.sv | 12 +
 rtl/can_bit_stuffer.sv | 92 +++++++++
 tb/tb_can_bit_stuffer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/can_bit_stuffer_pkg.sv
// Shared CAN definitions: stuffing run limit, line levels and stuffer state encoding.
package can_bit_stuffer_pkg;
  localparam int   CAN_STUFF_LIMIT = 5;
  localparam logic CAN_RECESSIVE   = 1'b1;
  localparam logic CAN_DOMINANT    = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_STUFF
  } stuff_state_e;
endpackage

// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: after STUFF_LIMIT identical line bits in the stuffed
// region, inserts one opposite bit while holding the sequencer via stuff_pending.
module can_bit_stuffer
  import can_bit_stuffer_pkg::*;
#(
  parameter int STUFF_LIMIT = CAN_STUFF_LIMIT,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             baud_tick,
  input  logic             txing,
  input  logic             stuff_en,
  input  logic             tx_bit,
  output logic             can_tx,
  output logic             stuff_pending,
  output logic [CNT_W-1:0] stuff_count
);
  localparam int               RUN_W   = $clog2(STUFF_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stuff_state_e     state_q, state_d;
  logic             last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             can_tx_q, can_tx_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    run_d    = run_q;
    can_tx_d = can_tx_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    if (baud_tick) begin
      if (!txing) begin
        // Leaving the frame also drops any stuff bit that was still due.
        state_d  = ST_IDLE;
        can_tx_d = CAN_RECESSIVE;
        last_d   = CAN_RECESSIVE;
        run_d    = '0;
        pend_d   = 1'b0;
        cnt_d    = '0;
      end else if (state_q == ST_STUFF) begin
        // tx_bit is ignored here; the stuff bit opens the next run.
        state_d  = ST_SEND;
        can_tx_d = ~last_q;
        last_d   = ~last_q;
        run_d    = RUN_W'(1);
        pend_d   = 1'b0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        state_d  = ST_SEND;
        can_tx_d = tx_bit;
        last_d   = tx_bit;
        pend_d   = 1'b0;
        if (tx_bit == last_q && run_q != '0)
          run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 1'b1;
        else
          run_d = RUN_W'(1);
        if (stuff_en && run_d == RUN_MAX) begin
          pend_d  = 1'b1;
          state_d = ST_STUFF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= CAN_RECESSIVE;
      run_q    <= '0;
      can_tx_q <= CAN_RECESSIVE;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      run_q    <= run_d;
      can_tx_q <= can_tx_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign can_tx        = can_tx_q;
  assign stuff_pending = pend_q;
  assign stuff_count   = cnt_q;
endmodule

// File: tb/tb_can_bit_stuffer.sv
// Scoreboard bench for can_bit_stuffer: a history-based stuffing model predicts
// each tick's line outputs; a monitor pops and compares after every tick edge.
module tb_can_bit_stuffer;
  localparam int LIM   = 5;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef struct packed {
    logic             tx;
    logic             pend;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic baud_tick = 1'b0, txing = 1'b0, stuff_en = 1'b0, tx_bit = 1'b0;
  logic can_tx, stuff_pending;
  logic [CNT_W-1:0] stuff_count;

  int total = 0, bad = 0;
  exp_t sb[$];
  bit fb[$];
  bit fe[$];

  always #5 clk = ~clk;

  can_bit_stuffer #(.STUFF_LIMIT(LIM), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .txing(txing),
    .stuff_en(stuff_en), .tx_bit(tx_bit), .can_tx(can_tx),
    .stuff_pending(stuff_pending), .stuff_count(stuff_count)
  );

  function automatic exp_t mk(input logic t, input logic p, input logic [CNT_W-1:0] c);
    exp_t x;
    x.tx = t; x.pend = p; x.cnt = c;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Stuffing is due when the last LIM line bits of this frame are identical.
  function automatic bit run_full(input bit h[$]);
    int n = h.size();
    if (n < LIM) return 1'b0;
    for (int k = n - LIM; k < n; k++)
      if (h[k] != h[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input logic t, input logic e, input logic b, input exp_t x);
    @(negedge clk);
    txing = t; stuff_en = e; tx_bit = b; baud_tick = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    baud_tick = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      txing = 1'($urandom); stuff_en = 1'($urandom); tx_bit = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_can_tx", 32'(can_tx), 32'd1);
    check("rst_pending", 32'(stuff_pending), 32'd0);
    check("rst_count", 32'(stuff_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays fb/fe as sequencer bits, honouring the hold-on-pending handshake.
  // cut: end the frame on the first pending stuff bit; rst_at: reset before that bit.
  task automatic run_frame(input bit cut, input int rst_at);
    bit hist[$];
    logic [CNT_W-1:0] cnt = '0;
    bit st, b;
    for (int i = 0; i < fb.size(); i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      b = fb[i];
      hist.push_back(b);
      st = fe[i] && run_full(hist);
      tick(1'b1, fe[i], b, mk(b, st, cnt));
      if (st) begin
        if (cut) begin
          tick(1'b0, 1'($urandom), 1'($urandom), mk(1'b1, 1'b0, '0));
          break;
        end
        if (cnt != CMAX) cnt = cnt + 1'b1;
        hist.push_back(!b);
        tick(1'b1, 1'($urandom), b, mk(!b, 1'b0, cnt));
      end
    end
    repeat (2) tick(1'b0, 1'($urandom), 1'($urandom), mk(1'b1, 1'b0, '0));
  endtask

  task automatic load(input logic [63:0] bits, input logic [63:0] ens, input int n);
    fb.delete(); fe.delete();
    for (int k = n - 1; k >= 0; k--) begin
      fb.push_back(bits[k]);
      fe.push_back(ens[k]);
    end
  endtask

  task automatic rand_frame();
    bit b;
    int n;
    fb.delete(); fe.delete();
    fb.push_back(1'b0); fe.push_back(1'b0);
    n = $urandom_range(5, 40);
    b = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      fb.push_back(b);
      fe.push_back($urandom_range(0, 9) != 0);
    end
    if ($urandom_range(0, 1) == 1)
      for (int k = 0; k < 10; k++) begin
        fb.push_back(1'b1); fe.push_back(1'b0);
      end
  endtask

  initial begin : monitor
    exp_t cur;
    logic tk;
    cur = mk(1'b1, 1'b0, '0);
    forever begin
      @(posedge clk);
      tk = baud_tick;
      #1;
      if (!rst_n) cur = mk(1'b1, 1'b0, '0);
      else if (tk) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: tick with no expected entry at %0t", $time);
        end else cur = sb.pop_front();
      end
      check("can_tx", 32'(can_tx), 32'(cur.tx));
      check("stuff_pending", 32'(stuff_pending), 32'(cur.pend));
      check("stuff_count", 32'(stuff_count), 32'(cur.cnt));
    end
  end

  initial begin : watchdog
    #5_000_000;
    bad++;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    #1;
    check("reset_can_tx", 32'(can_tx), 32'd1);
    check("reset_pending", 32'(stuff_pending), 32'd0);
    check("reset_count", 32'(stuff_count), 32'd0);
    rst_n = 1'b1;

    load(64'b00000110, 64'hFF, 8);           run_frame(1'b0, -1);
    load(64'b000001111, 64'h1FF, 9);         run_frame(1'b0, -1);
    load(64'b00000, 64'b01111, 5);           run_frame(1'b0, -1);
    load(64'b1111111, 64'd0, 7);             run_frame(1'b0, -1);
    load(64'b00000, 64'h1F, 5);              run_frame(1'b1, -1);
    load(64'b000000, 64'h3F, 6);             run_frame(1'b0, 3);
    load(64'b0000001, 64'h7F, 7);            run_frame(1'b0, -1);
    load(64'b0000001111111, 64'b1111110000001, 13); run_frame(1'b0, -1);

    fb.delete(); fe.delete();
    for (int k = 0; k < 100; k++) begin
      fb.push_back(1'b0); fe.push_back(1'b1);
    end
    run_frame(1'b0, -1);

    for (int f = 0; f < 60; f++) begin
      rand_frame();
      run_frame($urandom_range(0, 7) == 0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : -1);
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
